// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined floating-point multiplier (S1 classify, S2 multiply, S3 normalise/round/pack).
// Build option FP_MUL_RNE_EN selects round-to-nearest-even; when undefined the result truncates toward zero.
module fp_mul_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] prod,
    output logic [3:0]           flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [EXP_W+1:0] BIAS   = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EXP_W+1:0] E_ONE  = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] E_MAX  = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic signed [EXP_W+1:0] E_ZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Operand capture register
    logic         r1_valid;
    logic [W-1:0] r1_a, r1_b;

    // S1: unpack and classify
    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        fa, fb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                    s1_sign, s1_special, s1_invalid;
    logic [W-1:0]            s1_word;
    logic signed [EXP_W+1:0] s1_e;

    assign ea = r1_a[W-2 -: EXP_W];
    assign eb = r1_b[W-2 -: EXP_W];
    assign fa = r1_a[MAN_W-1:0];
    assign fb = r1_b[MAN_W-1:0];

    always_comb begin
        a_zero     = (ea == '0);
        b_zero     = (eb == '0);
        a_inf      = (ea == '1) && (fa == '0);
        b_inf      = (eb == '1) && (fb == '0);
        a_nan      = (ea == '1) && (fa != '0);
        b_nan      = (eb == '1) && (fb != '0);
        s1_sign    = r1_a[W-1] ^ r1_b[W-1];
        s1_invalid = a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero);
        s1_special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
        if (s1_invalid)
            s1_word = QNAN;
        else if (a_inf || b_inf)
            s1_word = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            s1_word = {s1_sign, {(W-1){1'b0}}};
        s1_e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    end

    logic                    r2_valid, r2_sign, r2_special, r2_invalid;
    logic [W-1:0]            r2_word;
    logic [MAN_W:0]          r2_ma, r2_mb;
    logic signed [EXP_W+1:0] r2_e;

    logic                    r3_valid, r3_sign, r3_special, r3_invalid;
    logic [W-1:0]            r3_word;
    logic [PW-1:0]           r3_p;
    logic signed [EXP_W+1:0] r3_e;

    // S3: normalise, round, range-check, pack
    logic [MAN_W-1:0]        frac_pre, frac_rnd;
    logic                    guard, sticky, round_inc, carry, inexact;
    logic signed [EXP_W+1:0] e_norm, e_rnd;
    logic [W-1:0]            s3_res;
    logic [3:0]              s3_flags;

    always_comb begin
        if (r3_p[PW-1]) begin
            frac_pre = r3_p[PW-2 -: MAN_W];
            guard    = r3_p[MAN_W];
            sticky   = |r3_p[MAN_W-1:0];
            e_norm   = r3_e + E_ONE;
        end else begin
            frac_pre = r3_p[PW-3 -: MAN_W];
            guard    = r3_p[MAN_W-1];
            sticky   = |r3_p[MAN_W-2:0];
            e_norm   = r3_e;
        end
`ifdef FP_MUL_RNE_EN
        round_inc = guard && (sticky || frac_pre[0]);
`else
        round_inc = 1'b0;
`endif
        {carry, frac_rnd} = {1'b0, frac_pre} + {{MAN_W{1'b0}}, round_inc};
        e_rnd   = carry ? (e_norm + E_ONE) : e_norm;
        inexact = guard || sticky;

        if (r3_special) begin
            s3_res   = r3_word;
            s3_flags = {r3_invalid, 3'b000};
        end else if (e_rnd >= E_MAX) begin
            s3_res   = {r3_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            s3_flags = 4'b0101;
        end else if (e_rnd <= E_ZERO) begin
            s3_res   = {r3_sign, {(W-1){1'b0}}};
            s3_flags = 4'b0011;
        end else begin
            s3_res   = {r3_sign, e_rnd[EXP_W-1:0], frac_rnd};
            s3_flags = {3'b000, inexact};
        end
    end

    // Only the valid bits and output registers are reset; payload registers are qualified by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            out_valid <= 1'b0;
            prod      <= '0;
            flags     <= '0;
        end else if (advance) begin
            r1_valid   <= in_valid;
            r1_a       <= a;
            r1_b       <= b;

            r2_valid   <= r1_valid;
            r2_sign    <= s1_sign;
            r2_special <= s1_special;
            r2_invalid <= s1_invalid;
            r2_word    <= s1_word;
            r2_ma      <= {1'b1, fa};
            r2_mb      <= {1'b1, fb};
            r2_e       <= s1_e;

            r3_valid   <= r2_valid;
            r3_sign    <= r2_sign;
            r3_special <= r2_special;
            r3_invalid <= r2_invalid;
            r3_word    <= r2_word;
            r3_p       <= {{(MAN_W+1){1'b0}}, r2_ma} * {{(MAN_W+1){1'b0}}, r2_mb};
            r3_e       <= r2_e;

            out_valid  <= r3_valid;
            if (r3_valid) begin
                prod  <= s3_res;
                flags <= s3_flags;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (single precision): directed vectors plus randomized traffic
// checked against an arithmetic reference model, with random backpressure and a mid-flight reset.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, prod;
    logic [3:0]  flags;

    always #5 clk = ~clk;

    fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .flags(flags)
    );

    int          checks = 0;
    int          failures = 0;
    int          delivered = 0;
    logic [35:0] exp_q[$];
    bit          stalled = 1'b0;
    logic [35:0] held;
    bit          rand_done = 1'b0;

    task automatic chk(input string name, input logic [35:0] got, input logic [35:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, expv, $time);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded part with half an ulp.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic             sx_sign, xnan, ynan, xinf, yinf, xzero, yzero, inexact;
        logic [7:0]       ex, ey;
        logic [22:0]      fx, fy;
        longint unsigned  p, keep, rem, half;
        int               msb, sh, e;
        sx_sign = x[31] ^ y[31];
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0];  fy = y[22:0];
        xnan  = (ex == 8'hFF) && (fx != 0);
        ynan  = (ey == 8'hFF) && (fy != 0);
        xinf  = (ex == 8'hFF) && (fx == 0);
        yinf  = (ey == 8'hFF) && (fy == 0);
        xzero = (ex == 8'h00);
        yzero = (ey == 8'h00);
        if (xnan || ynan || (xzero && yinf) || (yzero && xinf))
            return {4'b1000, 32'h7FC00000};
        if (xinf || yinf)
            return {4'b0000, sx_sign, 8'hFF, 23'd0};
        if (xzero || yzero)
            return {4'b0000, sx_sign, 31'd0};
        p = 64'({1'b1, fx}) * 64'({1'b1, fy});
        msb = 47;
        while (msb > 0 && p[msb] == 1'b0) msb--;
        sh   = msb - 23;
        keep = p >> sh;
        rem  = p - (keep << sh);
        half = 64'(1) << (sh - 1);
        e    = int'(ex) + int'(ey) - 127 + (msb - 46);
        inexact = (rem != 0);
`ifdef FP_MUL_RNE_EN
        if (rem > half || (rem == half && keep[0])) keep++;
`endif
        if (keep == (64'(1) << 24)) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, sx_sign, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, sx_sign, 31'd0};
        return {3'b000, inexact, sx_sign, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int          sel, fsel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2, 3:    e = 8'($urandom_range(1, 20));
            4, 5:    e = 8'($urandom_range(230, 254));
            default: e = 8'($urandom_range(100, 154));
        endcase
        fsel = $urandom_range(0, 7);
        if (fsel == 0)      f = '0;
        else if (fsel == 1) f = {4'($urandom_range(0, 15)), 19'd0};
        else                f = 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // Monitor: handshake rule, stall stability, in-order result checking.
    always @(negedge clk) begin
        logic [35:0] ev;
        if (!rst) begin
            chk("in_ready", {35'd0, in_ready}, {35'd0, (!out_valid || out_ready)});
            if (stalled)
                chk("stall_hold", {flags, prod} & {36{out_valid}}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output got=%h expected=none at %0t", {flags, prod}, $time);
                end else begin
                    ev = exp_q.pop_front();
                    chk("result", {flags, prod}, ev);
                    delivered++;
                end
            end
            stalled = out_valid && !out_ready;
            held    = {flags, prod};
        end else begin
            stalled = 1'b0;
        end
    end

    // Call at or just after a rising edge; returns at the edge where the operands were accepted.
    task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic [35:0] ev);
        bit acc;
        int tries;
        tries = 0;
        #1;
        in_valid = 1'b1;
        a = xa;
        b = xb;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            tries++;
        end while (!acc && tries < 2000);
        if (!acc) begin
            $display("FAIL send_timeout got=no_accept expected=accept at %0t", $time);
            failures++;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "input never accepted");
        end
        exp_q.push_back(ev);
    endtask

    task automatic idle(input int n);
        #1 in_valid = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic drain();
        int k;
        #1 in_valid = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        chk("drain", 36'(exp_q.size()), 36'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic time_one(input logic [31:0] xa, input logic [31:0] xb, input logic [35:0] ev);
        int k;
        send(xa, xb, ev);
        #1 in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", 36'(k), 36'd3);
    endtask

    initial begin
        int d0, seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {35'd0, out_valid}, 36'd0);
        chk("rst_prod", {4'd0, prod}, 36'd0);
        chk("rst_flags", {32'd0, flags}, 36'd0);
        chk("rst_in_ready", {35'd0, in_ready}, 36'd1);
        @(posedge clk);

        // Directed vectors
        time_one(32'h3FC00000, 32'h40000000, {4'b0000, 32'h40400000});
        drain();
`ifdef FP_MUL_RNE_EN
        send(32'h3F800001, 32'h3FC00000, {4'b0001, 32'h3FC00002});
`else
        send(32'h3F800001, 32'h3FC00000, {4'b0001, 32'h3FC00001});
`endif
        send(32'h7F000000, 32'h7F000000, {4'b0101, 32'h7F800000});
        send(32'h00800000, 32'h00800000, {4'b0011, 32'h00000000});
        send(32'h80000000, 32'h3F800000, {4'b0000, 32'h80000000});
        send(32'h00000000, 32'h7F800000, {4'b1000, 32'h7FC00000});
        send(32'h7FC00000, 32'h3F800000, {4'b1000, 32'h7FC00000});
        send(32'hFF800000, 32'h40000000, {4'b0000, 32'hFF800000});
        send(32'h00400000, 32'hC0000000, {4'b0000, 32'h80000000});
        drain();

        // Back-to-back stream with a 5-cycle output stall in the middle
        d0 = delivered;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [31:0] xa, xb;
                    xa = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
                    xb = {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
                    send(xa, xb, model(xa, xb));
                end
                #1 in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 36'(delivered - d0), 36'd10);

        // Reset with two operations in flight
        send(32'h3F800000, 32'h40400000, {4'b0000, 32'h40400000});
        send(32'h40000000, 32'h40000000, {4'b0000, 32'h40800000});
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        chk("rst_flush_valid", {35'd0, out_valid}, 36'd0);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("rst_flush_none", 36'(seen), 36'd0);
        time_one(32'h40400000, 32'h40400000, {4'b0000, 32'h41100000});
        drain();

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    logic [31:0] xa, xb;
                    xa = rand_op();
                    xb = rand_op();
                    send(xa, xb, model(xa, xb));
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                end
                #1 in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
